// File: rtl/is_div_3_top.sv
// Divisibility-by-3 detector: a balanced tree of mod-3 adders over 2-bit digit groups,
// with a combinational residue/flag and a one-cycle registered copy.
module is_div_3_top #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] digit,
  output logic            out,
  output logic [1:0]      residue,
  output logic            out_q,
  output logic [1:0]      res_q
);

  localparam int NG  = (SIZE + 1) / 2;
  localparam int LVL = (NG > 1) ? $clog2(NG) : 0;
  localparam int NP  = 1 << LVL;

  // Written as gate equations rather than a case table so that X/Z on digit propagates.
  function automatic logic [1:0] grp_mod3(input logic [1:0] g);
    grp_mod3 = {g[1] & ~g[0], g[0] & ~g[1]};
  endfunction

  // Operands use the 0..2 encoding; the result never reaches 3.
  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] s;
    s[0] = (~a[1] & ~a[0] & b[0]) | (a[0] & ~b[1] & ~b[0]) | (a[1] & b[1]);
    s[1] = (~a[1] & ~a[0] & b[1]) | (a[1] & ~b[1] & ~b[0]) | (a[0] & b[0]);
    add_mod3 = s;
  endfunction

  logic [2*NG-1:0] digit_pad;

  always_comb begin
    digit_pad             = '0;
    digit_pad[SIZE-1:0]   = digit;
  end

  // Level 0 holds one residue per 2-bit group; each level halves the node count.
  genvar lv, k;
  for (lv = 0; lv <= LVL; lv++) begin : g_lvl
    localparam int W = NP >> lv;
    logic [2*W-1:0] r;
    for (k = 0; k < W; k++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (k < NG) begin : g_grp
          assign r[2*k +: 2] = grp_mod3(digit_pad[2*k +: 2]);
        end else begin : g_pad
          assign r[2*k +: 2] = 2'b00;
        end
      end else begin : g_add
        assign r[2*k +: 2] = add_mod3(g_lvl[lv-1].r[4*k +: 2], g_lvl[lv-1].r[4*k+2 +: 2]);
      end
    end
  end

  assign residue = g_lvl[LVL].r[1:0];
  assign out     = (residue == 2'd0);

  // Registered copy, one cycle behind the combinational result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      res_q <= 2'd0;
    end else begin
      out_q <= out;
      res_q <= residue;
    end
  end

endmodule

// File: tb/tb_is_div_3_top.sv
// Directed and random checks of is_div_3_top at SIZE=64 and at the odd width SIZE=7.
module tb_is_div_3_top;

  logic        clk;
  logic        rst_n;
  logic [63:0] digit;
  logic        out;
  logic [1:0]  residue;
  logic        out_q;
  logic [1:0]  res_q;

  logic [6:0]  digit7;
  logic        out7;
  logic [1:0]  residue7;
  logic        out_q7;
  logic [1:0]  res_q7;

  int n_cmp;
  int n_fail;

  is_div_3_top #(.SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .digit(digit),
    .out(out), .residue(residue), .out_q(out_q), .res_q(res_q)
  );

  is_div_3_top #(.SIZE(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .digit(digit7),
    .out(out7), .residue(residue7), .out_q(out_q7), .res_q(res_q7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    digit  = 64'd0;
    digit7 = 7'd0;
    #1;
    n_cmp++;
    if (out_q !== 1'b0 || res_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: out_q=%b res_q=%0d, required 0/0", out_q, res_q);
    end
    n_cmp++;
    if (out !== 1'b1 || residue !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_operand: out=%b residue=%0d, required 1/0", out, residue);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: out_q=%b, required 0", out_q);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [1:0] exp_r;
    for (int i = 0; i <= 128; i++) begin
      digit = 64'(i);
      #1;
      exp_r = 2'(i % 3);
      n_cmp++;
      if (residue !== exp_r || out !== (exp_r == 2'd0)) begin
        n_fail++;
        $display("FAIL sweep digit=%0d: residue=%0d out=%b, required %0d/%b",
                 i, residue, out, exp_r, exp_r == 2'd0);
      end
    end
    digit = 64'd3;
    #1;
    n_cmp++;
    if (out !== 1'b1) begin
      n_fail++;
      $display("FAIL spot_3: out=%b, required 1", out);
    end
    digit = 64'd127;
    #1;
    n_cmp++;
    if (residue !== 2'd1 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL spot_127: residue=%0d out=%b, required 1/0", residue, out);
    end
    digit = 64'd128;
    #1;
    n_cmp++;
    if (residue !== 2'd2) begin
      n_fail++;
      $display("FAIL spot_128: residue=%0d, required 2", residue);
    end
  endtask

  task automatic test_extremes();
    digit = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_cmp++;
    if (out !== 1'b1 || residue !== 2'd0) begin
      n_fail++;
      $display("FAIL all_ones: out=%b residue=%0d, required 1/0", out, residue);
    end
    digit = 64'h8000_0000_0000_0000;
    #1;
    n_cmp++;
    if (residue !== 2'd2 || out !== 1'b0) begin
      n_fail++;
      $display("FAIL msb_only: residue=%0d out=%b, required 2/0", residue, out);
    end
    digit = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    n_cmp++;
    if (residue !== 2'd2) begin
      n_fail++;
      $display("FAIL all_ones_minus1: residue=%0d, required 2", residue);
    end
    digit = 64'h5555_5555_5555_5555;
    #1;
    n_cmp++;
    if (residue !== 2'd2) begin
      n_fail++;
      $display("FAIL alt_5555: residue=%0d, required 2", residue);
    end
  endtask

  task automatic test_odd_width();
    logic [1:0] exp_r;
    for (int i = 0; i < 128; i++) begin
      digit7 = 7'(i);
      #1;
      exp_r = 2'(i % 3);
      n_cmp++;
      if (residue7 !== exp_r || out7 !== (exp_r == 2'd0)) begin
        n_fail++;
        $display("FAIL odd7 digit=%0d: residue=%0d out=%b, required %0d/%b",
                 i, residue7, out7, exp_r, exp_r == 2'd0);
      end
    end
    digit7 = 7'h7F;
    #1;
    n_cmp++;
    if (residue7 !== 2'd1) begin
      n_fail++;
      $display("FAIL odd7_all_ones: residue=%0d, required 1", residue7);
    end
  endtask

  task automatic test_registered();
    @(posedge clk);
    #1 digit = 64'd9;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b1 || res_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reg_9: out_q=%b res_q=%0d, required 1/0", out_q, res_q);
    end
    digit = 64'd10;
    #1;
    n_cmp++;
    if (out_q !== 1'b1 || res_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reg_latency: out_q=%b res_q=%0d before edge, required 1/0", out_q, res_q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b0 || res_q !== 2'd1) begin
      n_fail++;
      $display("FAIL reg_10: out_q=%b res_q=%0d, required 0/1", out_q, res_q);
    end
  endtask

  task automatic test_reset_mid();
    digit = 64'd9;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: out_q=%b, required 1", out_q);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_q !== 1'b0 || res_q !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: out_q=%b res_q=%0d, required 0/0", out_q, res_q);
    end
    digit = 64'd11;
    #1;
    n_cmp++;
    if (out !== 1'b0 || residue !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_comb_track: out=%b residue=%0d, required 0/2", out, residue);
    end
    digit = 64'd12;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b0 || res_q !== 2'd0 || out !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_held: out_q=%b res_q=%0d out=%b, required 0/0/1", out_q, res_q, out);
    end
    #2 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out_q !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_release_no_edge: out_q=%b, required 0", out_q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_q !== 1'b1 || res_q !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_first_capture: out_q=%b res_q=%0d, required 1/0", out_q, res_q);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp_r;
    logic [1:0] prev_r;
    logic       have_prev;
    int         bad_r;
    int         bad_q;
    have_prev = 1'b0;
    prev_r    = 2'd0;
    bad_r     = 0;
    bad_q     = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (have_prev) begin
        n_cmp++;
        if (out_q !== (prev_r == 2'd0) || res_q !== prev_r) begin
          n_fail++;
          if (bad_q < 5)
            $display("FAIL rand_reg iter=%0d: out_q=%b res_q=%0d, required %b/%0d",
                     i, out_q, res_q, prev_r == 2'd0, prev_r);
          bad_q++;
        end
      end
      digit = {$urandom(), $urandom()};
      #1;
      exp_r = 2'(digit % 64'd3);
      n_cmp++;
      if (residue !== exp_r || out !== (exp_r == 2'd0)) begin
        n_fail++;
        if (bad_r < 5)
          $display("FAIL rand_comb digit=%h: residue=%0d out=%b, required %0d/%b",
                   digit, residue, out, exp_r, exp_r == 2'd0);
        bad_r++;
      end
      prev_r    = exp_r;
      have_prev = 1'b1;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_sweep();
    test_extremes();
    test_odd_width();
    test_registered();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
